// File: rtl/multi_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port multi_memory_core.
// A granted access drives the memory for LAT cycles, then returns a one-cycle ack.
module multi_mem_arbiter #(
  parameter int unsigned AW  = 10,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_spo,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;  // 1 = debug port was granted last
  logic          win_q, win_d;    // 1 = debug port owns the current access
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          grant_dbg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    // Debug wins when alone, or on a tie when the CPU was served last.
    grant_dbg   = dbg_req & (~cpu_req | ~last_q);
    unique case (state_q)
      StIdle: begin
        if (cpu_req | dbg_req) begin
          win_d   = grant_dbg;
          last_d  = grant_dbg;
          addr_d  = grant_dbg ? dbg_addr : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          we_d    = grant_dbg ? dbg_we : cpu_we;
          cnt_d   = CntInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (win_q) dbg_rdata_d = mem_spo;
            else       cpu_rdata_d = mem_spo;
          end
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_a   = '0;
    mem_d   = '0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dbg_ack = 1'b0;
    if (state_q == StAccess) begin
      mem_a  = addr_q;
      mem_d  = wdata_q;
      mem_we = we_q & (cnt_q == '0);
    end
    if (state_q == StResp) begin
      cpu_ack = ~win_q;
      dbg_ack = win_q;
    end
  end

  assign busy      = (state_q != StIdle);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  // Gated by reset so every output is quiet while reset is held.
  assign cpu_stall = rst & cpu_req & ~cpu_ack;

endmodule
